// File: rtl/serial_tx.sv
// serial_tx: parallel-in, serial-out UART-style transmitter.
// A word is accepted through a valid/ready handshake and then sent as
// start bit (0), DATA_W data bits LSB first and stop bit (1). Each bit
// is held on the line for CLKS_PER_BIT clock cycles.
module serial_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  output logic              tx_out,
  output logic              busy,
  output logic              tx_done
);

  // Counter widths never drop below one bit so CLKS_PER_BIT=1 / DATA_W=1 still elaborate.
  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_START = 2'b01,
    ST_DATA  = 2'b10,
    ST_STOP  = 2'b11
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [BAUD_W-1:0]   r_baud;
  logic [BAUD_W-1:0]   w_baud_nxt;
  logic [BIT_W-1:0]    r_bit;
  logic [BIT_W-1:0]    w_bit_nxt;
  logic [DATA_W-1:0]   r_shift;
  logic [DATA_W-1:0]   w_shift_nxt;
  logic                w_baud_wrap;

  logic                r_tx_out;
  logic                r_tx_ready;
  logic                r_busy;
  logic                r_tx_done;
  logic                w_tx_out_nxt;
  logic                w_tx_ready_nxt;
  logic                w_busy_nxt;
  logic                w_tx_done_nxt;

  // Next-state, counter and shift-register logic of the frame sequencer.
  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_baud_wrap = (r_baud == BAUD_LAST);

    case (r_state)
      ST_IDLE: begin
        w_baud_nxt = '0;
        w_bit_nxt  = '0;
        if (tx_valid) begin
          w_state_nxt = ST_START;
          w_shift_nxt = tx_data;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_START: begin
        if (w_baud_wrap) begin
          w_state_nxt = ST_DATA;
          w_baud_nxt  = '0;
        end else begin
          w_baud_nxt  = r_baud + BAUD_W'(1);
        end
      end
      ST_DATA: begin
        if (w_baud_wrap) begin
          w_baud_nxt  = '0;
          w_shift_nxt = r_shift >> 1;
          if (r_bit == BIT_LAST) begin
            w_state_nxt = ST_STOP;
            w_bit_nxt   = '0;
          end else begin
            w_bit_nxt   = r_bit + BIT_W'(1);
          end
        end else begin
          w_baud_nxt  = r_baud + BAUD_W'(1);
        end
      end
      ST_STOP: begin
        if (w_baud_wrap) begin
          w_state_nxt = ST_IDLE;
          w_baud_nxt  = '0;
        end else begin
          w_baud_nxt  = r_baud + BAUD_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_baud_nxt  = '0;
        w_bit_nxt   = '0;
      end
    endcase
  end

  // Output values decoded from the next state so the registered outputs line up with it.
  always_comb begin
    w_tx_ready_nxt = (w_state_nxt == ST_IDLE);
    w_busy_nxt     = (w_state_nxt != ST_IDLE);
    w_tx_done_nxt  = (w_state_nxt == ST_STOP) && (w_baud_nxt == BAUD_LAST);
    case (w_state_nxt)
      ST_START: w_tx_out_nxt = 1'b0;
      ST_DATA:  w_tx_out_nxt = w_shift_nxt[0];
      default:  w_tx_out_nxt = 1'b1;
    endcase
  end

  // State, counters, shift register and registered outputs; reset forces an idle line at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_baud     <= '0;
      r_bit      <= '0;
      r_shift    <= '0;
      r_tx_out   <= 1'b1;
      r_tx_ready <= 1'b1;
      r_busy     <= 1'b0;
      r_tx_done  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_baud     <= w_baud_nxt;
      r_bit      <= w_bit_nxt;
      r_shift    <= w_shift_nxt;
      r_tx_out   <= w_tx_out_nxt;
      r_tx_ready <= w_tx_ready_nxt;
      r_busy     <= w_busy_nxt;
      r_tx_done  <= w_tx_done_nxt;
    end
  end

  assign tx_out   = r_tx_out;
  assign tx_ready = r_tx_ready;
  assign busy     = r_busy;
  assign tx_done  = r_tx_done;

endmodule
